alu_cmd_driver: RTL and testbench

Sequential initiator for the combinational ALU: accepts one arithmetic command at a time over a valid/ready handshake, drives the ALU's `a`/`b`/`opcode` inputs from registers, and waits for the ALU's `ready`. It captures `result`, screens divide-by-zero before issue, enforces a ready timeout, and returns result plus status over a second valid/ready handshake. It sits between the command source (sequencer or bus adapter) and the ALU instance.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_cmd_driver.sv | 139 +++++++++++++
 tb/tb_alu_cmd_driver.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command driver: opcodes, response
// status codes, driver FSM state type and the default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_DIV0    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } drv_state_e;

endpackage

// File: rtl/alu_cmd_driver.sv
// Single-outstanding command initiator for the combinational ALU: issues
// registered operands, waits (bounded) for alu_ready, returns result + status.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       rsp_status,
    output logic [7:0]       err_count,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ready
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    drv_state_e       state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]       rsp_status_q, rsp_status_d;
    logic [7:0]       err_count_q, err_count_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_opcode_q, alu_opcode_d;

    // Next-state and next-output computation for the IDLE/WAIT/RESP sequencer.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        err_count_d  = err_count_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_opcode_d = alu_opcode_q;
        case (state_q)
            S_IDLE: begin
                // cmd_ready_q is low for the first cycle after reset release
                if (cmd_ready_q && cmd_valid) begin
                    alu_a_d      = cmd_a;
                    alu_b_d      = cmd_b;
                    alu_opcode_d = cmd_op;
                    if ((cmd_op == OP_DIV) && (cmd_b == {WIDTH{1'b0}})) begin
                        rsp_data_d   = {WIDTH{1'b0}};
                        rsp_status_d = ST_DIV0;
                        state_d      = S_RESP;
                    end else begin
                        wait_cnt_d = 8'd0;
                        state_d    = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (alu_ready) begin
                    rsp_data_d   = alu_result;
                    rsp_status_d = ST_OK;
                    state_d      = S_RESP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    rsp_data_d   = {WIDTH{1'b0}};
                    rsp_status_d = ST_TIMEOUT;
                    state_d      = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    if ((rsp_status_q != ST_OK) && (err_count_q != 8'hFF)) begin
                        err_count_d = err_count_q + 8'd1;
                    end else begin
                        err_count_d = err_count_q;
                    end
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= 8'd0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= {WIDTH{1'b0}};
            rsp_status_q <= 2'b00;
            err_count_q  <= 8'd0;
            alu_a_q      <= {WIDTH{1'b0}};
            alu_b_q      <= {WIDTH{1'b0}};
            alu_opcode_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            err_count_q  <= err_count_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign err_count  = err_count_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Randomized self-checking bench for alu_cmd_driver with an ALU stand-in whose
// ready can be stalled per command; expectations come from a transaction model.
module tb_alu_cmd_driver;

    localparam int W  = 32;
    localparam int TO = 15;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [1:0]   cmd_op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic [1:0]   rsp_status;
    logic [7:0]   err_count;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_opcode;
    logic [W-1:0] alu_result;
    logic         alu_ready;

    int checks_s;
    int failures_s;
    int model_err_s;

    alu_cmd_driver #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_status(rsp_status), .err_count(err_count),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_ready(alu_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU stand-in driven from the DUT's registered operands.
    always_comb begin
        case (alu_opcode)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a * alu_b;
            default: alu_result = (alu_b == 32'd0) ? 32'd0 : alu_a / alu_b;
        endcase
    end

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks_s++;
        if (got !== exp) begin
            failures_s++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: result of a command from plain 64-bit arithmetic.
    function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        longint unsigned la, lb, r;
        la = a;
        lb = b;
        case (op)
            2'd0:    r = la + lb;
            2'd1:    r = la - lb;
            2'd2:    r = la * lb;
            default: r = la / lb;
        endcase
        return r[W-1:0];
    endfunction

    // One full transaction; stall = cycles of alu_ready low before it rises,
    // hold = extra cycles rsp_ready stays low while the response is checked.
    task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                           input int stall, input int hold, input bit full);
        int lat;
        int exp_lat;
        int guard;
        logic [W-1:0] exp_data;
        logic [1:0] exp_st;
        if (op == 2'd3 && b == 32'd0) begin
            exp_data = 32'd0; exp_st = 2'b01; exp_lat = 0;
        end else if (stall >= TO) begin
            exp_data = 32'd0; exp_st = 2'b10; exp_lat = TO;
        end else begin
            exp_data = ref_result(a, b, op); exp_st = 2'b00; exp_lat = stall + 1;
        end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        alu_ready = (stall == 0);
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check_val("accept_timeout", 32'(guard), 32'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (full) begin
            check_val("alu_a", alu_a, a);
            check_val("alu_b", alu_b, b);
            check_val("alu_op", 32'(alu_opcode), 32'(op));
        end
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            alu_ready = (lat >= stall);
            @(posedge clk); #1;
            lat++;
        end
        alu_ready = 1'b1;
        if (full) check_val("latency", 32'(lat), 32'(exp_lat));
        check_val("rsp_data", rsp_data, exp_data);
        check_val("rsp_status", 32'(rsp_status), 32'(exp_st));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val("hold_valid", 32'(rsp_valid), 32'd1);
            check_val("hold_data", rsp_data, exp_data);
            check_val("hold_status", 32'(rsp_status), 32'(exp_st));
            check_val("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (exp_st != 2'b00 && model_err_s < 255) model_err_s++;
        if (full) begin
            check_val("rsp_valid_drop", 32'(rsp_valid), 32'd0);
            check_val("cmd_ready_back", 32'(cmd_ready), 32'd1);
            check_val("err_count", 32'(err_count), 32'(model_err_s));
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [1:0]   rop;
        int           rstall;
        checks_s = 0; failures_s = 0; model_err_s = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = 32'd0; cmd_b = 32'd0; cmd_op = 2'b00;
        rsp_ready = 1'b0; alu_ready = 1'b1;
        #22;
        check_val("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_err", 32'(err_count), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        run_cmd(32'd5, 32'd7, 2'b00, 0, 0, 1'b1);
        run_cmd(32'hFFFF_FFFF, 32'd2, 2'b00, 0, 0, 1'b1);
        run_cmd(32'h0001_0000, 32'h0001_0000, 2'b10, 0, 0, 1'b1);
        run_cmd(32'd100, 32'd0, 2'b11, 0, 0, 1'b1);
        run_cmd(32'd20, 32'd30, 2'b01, 100, 4, 1'b1);
        run_cmd(32'd8, 32'd3, 2'b10, TO - 1, 0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom; rb = $urandom; rop = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) rb = 32'd0;
            rstall = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TO - 1, TO + 2)) : int'($urandom_range(0, 3));
            run_cmd(ra, rb, rop, rstall, int'($urandom_range(0, 2)), 1'b1);
        end

        for (int n = 0; n < 300; n++) run_cmd(32'($urandom), 32'd0, 2'b11, 0, 0, 1'b0);
        check_val("err_saturated", 32'(err_count), 32'd255);
        run_cmd(32'd9, 32'd3, 2'b11, 0, 0, 1'b1);

        // Reset while the command is parked in WAIT with the ALU stalled.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = 32'd11; cmd_b = 32'd4; cmd_op = 2'b00; alu_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check_val("mid_rst_data", rsp_data, 32'd0);
        check_val("mid_rst_err", 32'(err_count), 32'd0);
        check_val("mid_rst_alu_a", alu_a, 32'd0);
        model_err_s = 0;
        alu_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        run_cmd(32'd1, 32'd1, 2'b01, 0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
        $finish;
    end

endmodule
